multicycle_control: RTL and testbench
=====================================

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 The block SHALL have `clk`  in  1  the single clock; all state changes on the rising edge.
REQ-002 The block SHALL have `reset`  in  1  asynchronous, active-high reset.
REQ-003 The block SHALL have `op`  in  6  opcode field from the instruction register; stable from DECODE onward.
REQ-004 The block SHALL have `memready`  in  1  memory handshake; completes the current memory access in the cycle it is high.
REQ-005 The block SHALL have `pcwrite`, `pcwritecond`, `irwrite`  out  1 each; strobes for unconditional PC write, branch-conditional PC write and IR load.
REQ-006 The block SHALL have `iord`, `memread`, `memwrite`  out  1 each; memory address select (0=PC, 1=ALUOut) and access strobes.
REQ-007 The block SHALL have `regdest`, `regwrite`, `memtoreg`  out  1 each; register-file destination select (1=rd), write enable and writeback select (1=MDR).
REQ-008 The block SHALL have `alusrca`  out  1 (0=PC, 1=rs) and `alusrcb`  out  2 (00=rt, 01=4, 10=signext imm, 11=signext imm<<2).
REQ-009 The block SHALL have `aluop`  out  3: 000 add, 001 R-type, 010 beq, 011 ben, 100 bvf.
REQ-010 The block SHALL have `pcsource`  out  2: 00 ALU result, 01 ALUOut, 10 jump target.
REQ-011 The block SHALL have `illegal`  out  1 (one-cycle pulse on undecodable opcode) and `state`  out  4 (current state, for debug).

Function
REQ-012 Opcodes SHALL be: R 000000, lw 100011, sw 101011, beq 000100, bvf 000101, ben 000110, j 000010, addi 001000.
REQ-013 States SHALL be: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, RWB=7, BRANCH=8, JUMP=9, ADDIEX=10, ADDIWB=11.
REQ-014 All outputs not named for a state SHALL be 0 in that state (decoded from the state register).
REQ-015 FETCH SHALL drive memread=1, iord=0, alusrca=0, alusrcb=01, aluop=000, pcsource=00, and hold until memready=1.
REQ-016 In FETCH, irwrite and pcwrite SHALL equal memready (combinational gating); memready=1 SHALL advance FETCH to DECODE.
REQ-017 DECODE SHALL drive alusrca=0, alusrcb=11, aluop=000, then dispatch: lw/sw->MEMADR, R->EXEC, beq/ben/bvf->BRANCH, j->JUMP, addi->ADDIEX, otherwise pulse illegal=1 and go to FETCH.
REQ-018 MEMADR SHALL drive alusrca=1, alusrcb=10, aluop=000, then go to MEMRD for lw or MEMWR for sw.
REQ-019 MEMRD SHALL drive memread=1, iord=1, holding until memready=1, then go to MEMWB.
REQ-020 MEMWR SHALL drive memwrite=1, iord=1, holding until memready=1, then go to FETCH.
REQ-021 MEMWB SHALL drive regwrite=1, memtoreg=1, regdest=0, then go to FETCH.
REQ-022 EXEC SHALL drive alusrca=1, alusrcb=00, aluop=001, then go to RWB. RWB SHALL drive regwrite=1, regdest=1, memtoreg=0, then go to FETCH.
REQ-023 ADDIEX SHALL drive alusrca=1, alusrcb=10, aluop=000, then go to ADDIWB. ADDIWB SHALL drive regwrite=1, regdest=0, memtoreg=0, then go to FETCH.
REQ-024 BRANCH SHALL drive alusrca=1, alusrcb=00, pcwritecond=1, pcsource=01, aluop=010/011/100 for beq/ben/bvf, then go to FETCH.
REQ-025 JUMP SHALL drive pcwrite=1, pcsource=10, then go to FETCH.
REQ-026 With zero-wait memory, instruction latency in cycles SHALL be: branch 3, j 3, sw 4, R 4, addi 4, lw 5. Each wait cycle SHALL add one cycle.
REQ-027 memready SHALL be ignored outside FETCH/MEMRD/MEMWR. memread and memwrite SHALL never be high simultaneously.
REQ-028 Unused 4-bit state encodings (12-15) SHALL transition to FETCH on the next edge, with all strobes 0.

Reset
REQ-029 reset=1 SHALL force state=FETCH immediately (asynchronously), including mid-access; strobes SHALL then follow FETCH decoding with irwrite=pcwrite=0 while reset is high.
REQ-030 After reset deassertion, the first rising edge SHALL evaluate FETCH normally; illegal SHALL be 0 during reset.

Structure
REQ-031 A shared package SHALL hold the opcode constants, the state encodings and the aluop/alusrcb/pcsource encodings.
REQ-032 The block SHALL be a single module: a state register plus next-state and output decode. Opcode decoding SHALL be reusable as an optional sub-module `opdecode`, which outputs one-hot instruction class.

Verification
REQ-033 R-type: reset, op=000000, memready=1 constantly -> states 0,1,6,7,0; regwrite=1 and regdest=1 only in cycle 4.
REQ-034 lw with 2 wait cycles in MEMRD: op=100011 -> 0,1,2,3,3,3,4,0; memread=iord=1 for three cycles, then memtoreg=regwrite=1.
REQ-035 Fetch wait: memready=0 for 3 cycles -> state stays 0, irwrite=pcwrite=0; memready=1 -> irwrite=pcwrite=1 for one cycle.
REQ-036 Branch variants: op=000100/000110/000101 -> BRANCH with aluop 010/011/100, pcwritecond=1, pcsource=01.
REQ-037 Illegal op=111111 -> illegal=1 for one cycle in DECODE, next state 0, no register or memory write.
REQ-038 reset asserted mid-MEMWR -> state=0 and memwrite=0 without a clock edge; normal fetch resumes after release.

Source files
------------

// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multicycle controller: opcodes, states,
// ALU/mux selects, the one-hot instruction class and the control bundle.
package multicycle_control_pkg;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BVF  = 6'b000101;
    localparam logic [5:0] OP_BEN  = 6'b000110;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_RWB    = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_ADDIEX = 4'd10,
        S_ADDIWB = 4'd11
    } state_t;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_RTYPE = 3'b001;
    localparam logic [2:0] ALU_BEQ   = 3'b010;
    localparam logic [2:0] ALU_BEN   = 3'b011;
    localparam logic [2:0] ALU_BVF   = 3'b100;

    localparam logic [1:0] SRCB_RT    = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    localparam logic [1:0] PCS_ALU    = 2'b00;
    localparam logic [1:0] PCS_ALUOUT = 2'b01;
    localparam logic [1:0] PCS_JUMP   = 2'b10;

    // One-hot instruction class; all zero means undecodable opcode.
    typedef struct packed {
        logic r;
        logic lw;
        logic sw;
        logic beq;
        logic ben;
        logic bvf;
        logic j;
        logic addi;
    } iclass_t;

    // Datapath control bundle decoded from the state register.
    typedef struct packed {
        logic       pcwrite;
        logic       pcwritecond;
        logic       irwrite;
        logic       iord;
        logic       memread;
        logic       memwrite;
        logic       regdest;
        logic       regwrite;
        logic       memtoreg;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [2:0] aluop;
        logic [1:0] pcsource;
        logic       illegal;
    } ctrl_t;

endpackage

// File: rtl/multicycle_control_opdecode.sv
// Opcode to one-hot instruction class decoder.
module opdecode
    import multicycle_control_pkg::*;
(
    input  logic [5:0] op,
    output iclass_t    cls
);

    // Pure lookup; unknown opcodes leave every class bit low.
    always_comb begin
        cls = '0;
        case (op)
            OP_R:    cls.r    = 1'b1;
            OP_LW:   cls.lw   = 1'b1;
            OP_SW:   cls.sw   = 1'b1;
            OP_BEQ:  cls.beq  = 1'b1;
            OP_BEN:  cls.ben  = 1'b1;
            OP_BVF:  cls.bvf  = 1'b1;
            OP_J:    cls.j    = 1'b1;
            OP_ADDI: cls.addi = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle CPU controller: state register, next-state logic and
// control outputs decoded from the current state.
module multicycle_control
    import multicycle_control_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic       memready,
    output logic       pcwrite,
    output logic       pcwritecond,
    output logic       irwrite,
    output logic       iord,
    output logic       memread,
    output logic       memwrite,
    output logic       regdest,
    output logic       regwrite,
    output logic       memtoreg,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [2:0] aluop,
    output logic [1:0] pcsource,
    output logic       illegal,
    output logic [3:0] state
);

    state_t  st, nxt;
    iclass_t cls;
    ctrl_t   ctl;

    opdecode u_dec (.op(op), .cls(cls));

    // State register; reset lands in FETCH without waiting for an edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) st <= S_FETCH;
        else       st <= nxt;
    end

    // Next state; memory states hold until memready, stray encodings recover to FETCH.
    always_comb begin
        nxt = S_FETCH;
        case (st)
            S_FETCH:  nxt = memready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                if (cls.lw || cls.sw)                  nxt = S_MEMADR;
                else if (cls.r)                        nxt = S_EXEC;
                else if (cls.beq || cls.ben || cls.bvf) nxt = S_BRANCH;
                else if (cls.j)                        nxt = S_JUMP;
                else if (cls.addi)                     nxt = S_ADDIEX;
                else                                   nxt = S_FETCH;
            end
            S_MEMADR: nxt = cls.sw ? S_MEMWR : S_MEMRD;
            S_MEMRD:  nxt = memready ? S_MEMWB : S_MEMRD;
            S_MEMWR:  nxt = memready ? S_FETCH : S_MEMWR;
            S_EXEC:   nxt = S_RWB;
            S_ADDIEX: nxt = S_ADDIWB;
            default:  nxt = S_FETCH;
        endcase
    end

    // Control decode; IR/PC load in FETCH is gated by memready and suppressed in reset.
    always_comb begin
        ctl = '0;
        case (st)
            S_FETCH: begin
                ctl.memread = 1'b1;
                ctl.alusrcb = SRCB_FOUR;
                ctl.irwrite = memready & ~reset;
                ctl.pcwrite = memready & ~reset;
            end
            S_DECODE: begin
                ctl.alusrcb = SRCB_IMMSH;
                ctl.illegal = ~(|cls);
            end
            S_MEMADR, S_ADDIEX: begin
                ctl.alusrca = 1'b1;
                ctl.alusrcb = SRCB_IMM;
            end
            S_MEMRD: begin
                ctl.memread = 1'b1;
                ctl.iord    = 1'b1;
            end
            S_MEMWR: begin
                ctl.memwrite = 1'b1;
                ctl.iord     = 1'b1;
            end
            S_MEMWB: begin
                ctl.regwrite = 1'b1;
                ctl.memtoreg = 1'b1;
            end
            S_EXEC: begin
                ctl.alusrca = 1'b1;
                ctl.aluop   = ALU_RTYPE;
            end
            S_RWB: begin
                ctl.regwrite = 1'b1;
                ctl.regdest  = 1'b1;
            end
            S_ADDIWB: ctl.regwrite = 1'b1;
            S_BRANCH: begin
                ctl.alusrca     = 1'b1;
                ctl.pcwritecond = 1'b1;
                ctl.pcsource    = PCS_ALUOUT;
                ctl.aluop       = cls.ben ? ALU_BEN : (cls.bvf ? ALU_BVF : ALU_BEQ);
            end
            S_JUMP: begin
                ctl.pcwrite  = 1'b1;
                ctl.pcsource = PCS_JUMP;
            end
            default: ;
        endcase
    end

    assign pcwrite     = ctl.pcwrite;
    assign pcwritecond = ctl.pcwritecond;
    assign irwrite     = ctl.irwrite;
    assign iord        = ctl.iord;
    assign memread     = ctl.memread;
    assign memwrite    = ctl.memwrite;
    assign regdest     = ctl.regdest;
    assign regwrite    = ctl.regwrite;
    assign memtoreg    = ctl.memtoreg;
    assign alusrca     = ctl.alusrca;
    assign alusrcb     = ctl.alusrcb;
    assign aluop       = ctl.aluop;
    assign pcsource    = ctl.pcsource;
    assign illegal     = ctl.illegal;
    assign state       = st;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench: directed instruction sequences plus random traffic
// compared every cycle against an instruction-plan model.
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] op = 6'd0;
    logic       memready = 1'b1;
    logic       pcwrite, pcwritecond, irwrite, iord, memread, memwrite;
    logic       regdest, regwrite, memtoreg, alusrca, illegal;
    logic [1:0] alusrcb, pcsource;
    logic [2:0] aluop;
    logic [3:0] state;

    int checks = 0;
    int failures = 0;

    multicycle_control dut (
        .clk(clk), .reset(reset), .op(op), .memready(memready),
        .pcwrite(pcwrite), .pcwritecond(pcwritecond), .irwrite(irwrite),
        .iord(iord), .memread(memread), .memwrite(memwrite),
        .regdest(regdest), .regwrite(regwrite), .memtoreg(memtoreg),
        .alusrca(alusrca), .alusrcb(alusrcb), .aluop(aluop),
        .pcsource(pcsource), .illegal(illegal), .state(state)
    );

    always #5 clk = ~clk;

    logic [16:0] dut_vec;
    assign dut_vec = {pcwrite, pcwritecond, irwrite, iord, memread, memwrite,
                      regdest, regwrite, memtoreg, alusrca, alusrcb, aluop,
                      pcsource, illegal};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    // ---------------- reference model ----------------
    // Instruction class: 0 R, 1 lw, 2 sw, 3 branch, 4 j, 5 addi, 6 illegal.
    function automatic int cls_of(input logic [5:0] o);
        case (o)
            6'b000000: return 0;
            6'b100011: return 1;
            6'b101011: return 2;
            6'b000100, 6'b000101, 6'b000110: return 3;
            6'b000010: return 4;
            6'b001000: return 5;
            default:   return 6;
        endcase
    endfunction

    // State visited at step i after FETCH (step 0 is DECODE); 0 = back to FETCH.
    function automatic int plan_at(input int c, input int i);
        int r0[3] = '{1, 6, 7};
        int r1[4] = '{1, 2, 3, 4};
        int r2[3] = '{1, 2, 5};
        int r3[2] = '{1, 8};
        int r4[2] = '{1, 9};
        int r5[3] = '{1, 10, 11};
        case (c)
            0: return (i < 3) ? r0[i] : 0;
            1: return (i < 4) ? r1[i] : 0;
            2: return (i < 3) ? r2[i] : 0;
            3: return (i < 2) ? r3[i] : 0;
            4: return (i < 2) ? r4[i] : 0;
            5: return (i < 3) ? r5[i] : 0;
            default: return (i < 1) ? 1 : 0;
        endcase
    endfunction

    int mst = 0, mcls = 0, pidx = 0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mst <= 0;
            pidx <= 0;
        end else if (mst == 0) begin
            if (memready) begin
                mcls <= cls_of(op);
                pidx <= 0;
                mst  <= 1;
            end
        end else if ((mst == 3 || mst == 5) && !memready) begin
            mst <= mst;
        end else begin
            mst  <= plan_at(mcls, pidx + 1);
            pidx <= pidx + 1;
        end
    end

    // Expected control outputs for a state, in the same bit order as dut_vec.
    function automatic logic [16:0] exp_vec(input int s, input logic [5:0] o,
                                            input logic mr, input logic rst);
        logic pw, pwc, irw, io, mrd, mwr, rd, rw, m2r, sa, il;
        logic [1:0] sb, ps;
        logic [2:0] ao;
        {pw, pwc, irw, io, mrd, mwr, rd, rw, m2r, sa, il} = '0;
        sb = 2'b00; ps = 2'b00; ao = 3'b000;
        case (s)
            0:  begin mrd = 1; sb = 2'b01; irw = mr & ~rst; pw = mr & ~rst; end
            1:  begin sb = 2'b11; il = (cls_of(o) == 6); end
            2:  begin sa = 1; sb = 2'b10; end
            3:  begin mrd = 1; io = 1; end
            4:  begin rw = 1; m2r = 1; end
            5:  begin mwr = 1; io = 1; end
            6:  begin sa = 1; ao = 3'b001; end
            7:  begin rw = 1; rd = 1; end
            8:  begin
                    sa = 1; pwc = 1; ps = 2'b01;
                    ao = (o == 6'b000110) ? 3'b011 : (o == 6'b000101) ? 3'b100 : 3'b010;
                end
            9:  begin pw = 1; ps = 2'b10; end
            10: begin sa = 1; sb = 2'b10; end
            11: rw = 1;
            default: ;
        endcase
        return {pw, pwc, irw, io, mrd, mwr, rd, rw, m2r, sa, sb, ao, ps, il};
    endfunction

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        chk("state", {28'd0, state}, mst);
        chk("ctrl", {15'd0, dut_vec}, {15'd0, exp_vec(mst, op, memready, reset)});
        chk("rd_wr_excl", {31'd0, memread & memwrite}, 0);
    end

    // ---------------- directed + random stimulus ----------------
    task automatic set(input logic [5:0] o, input logic mr);
        op = o; memready = mr; #1;
    endtask

    task automatic adv();
        @(posedge clk); #1;
    endtask

    function automatic logic [5:0] pick();
        logic [5:0] t [8] = '{6'b000000, 6'b100011, 6'b101011, 6'b000100,
                              6'b000101, 6'b000110, 6'b000010, 6'b001000};
        int k = $urandom_range(0, 8);
        return (k == 8) ? 6'($urandom_range(0, 63)) : t[k];
    endfunction

    initial begin
        int wait_rd;
        logic [5:0] bops [3] = '{6'b000100, 6'b000110, 6'b000101};
        logic [2:0] baos [3] = '{3'b010, 3'b011, 3'b100};

        // Reset state
        adv();
        chk("rst_state", {28'd0, state}, 0);
        chk("rst_irwrite", {31'd0, irwrite | pcwrite}, 0);
        chk("rst_memread", {31'd0, memread}, 1);
        chk("rst_illegal", {31'd0, illegal}, 0);
        reset = 1'b0;

        // R-type, zero wait: 0,1,6,7
        set(6'b000000, 1); chk("r_s0", state, 0); chk("r_irw", irwrite, 1); adv();
        set(6'b000000, 1); chk("r_s1", state, 1); chk("r_rw1", regwrite, 0); adv();
        set(6'b000000, 1); chk("r_s2", state, 6); chk("r_aluop", aluop, 3'b001); adv();
        set(6'b000000, 1); chk("r_s3", state, 7); chk("r_rw", {regwrite, regdest}, 2'b11); adv();

        // lw with two MEMRD wait cycles: 0,1,2,3,3,3,4
        set(6'b100011, 1); chk("lw_s0", state, 0); adv();
        set(6'b100011, 1); chk("lw_s1", state, 1); adv();
        set(6'b100011, 1); chk("lw_s2", state, 2); chk("lw_srcb", alusrcb, 2'b10); adv();
        wait_rd = 0;
        for (int i = 0; i < 3; i++) begin
            set(6'b100011, (i == 2));
            chk("lw_s3", state, 3);
            if (memread && iord) wait_rd++;
            adv();
        end
        chk("lw_rd_cycles", wait_rd, 3);
        set(6'b100011, 1); chk("lw_s4", state, 4); chk("lw_wb", {memtoreg, regwrite}, 2'b11); adv();

        // Fetch wait then jump
        for (int i = 0; i < 3; i++) begin
            set(6'b000010, 0);
            chk("fw_state", state, 0);
            chk("fw_irpc", {irwrite, pcwrite}, 2'b00);
            adv();
        end
        set(6'b000010, 1); chk("fw_go", {irwrite, pcwrite}, 2'b11); adv();
        set(6'b000010, 1); chk("j_dec", state, 1); chk("j_irw", irwrite, 0); adv();
        set(6'b000010, 1); chk("j_state", state, 9); chk("j_pc", {pcwrite, pcsource}, 3'b110); adv();

        // Branch variants
        for (int b = 0; b < 3; b++) begin
            set(bops[b], 1); adv();
            set(bops[b], 1); adv();
            set(bops[b], 1);
            chk("br_state", state, 8);
            chk("br_aluop", aluop, baos[b]);
            chk("br_pwc_ps", {pcwritecond, pcsource}, 3'b101);
            adv();
        end

        // Illegal opcode
        set(6'b111111, 1); adv();
        set(6'b111111, 1);
        chk("ill_state", state, 1);
        chk("ill_pulse", illegal, 1);
        chk("ill_nowr", {regwrite, memwrite}, 2'b00);
        adv();
        set(6'b111111, 0); chk("ill_next", state, 0); chk("ill_clr", illegal, 0); adv();

        // Async reset in the middle of MEMWR
        set(6'b101011, 1); adv();
        set(6'b101011, 1); adv();
        set(6'b101011, 1); adv();
        set(6'b101011, 0); chk("sw_state", state, 5); chk("sw_mw", memwrite, 1);
        reset = 1'b1; #1;
        chk("arst_state", state, 0);
        chk("arst_mw", memwrite, 0);
        adv();
        reset = 1'b0;
        set(6'b000000, 1); chk("resume_s0", state, 0); chk("resume_irw", irwrite, 1); adv();
        set(6'b000000, 1); chk("resume_s1", state, 1); adv();

        // Random traffic, checked by the every-cycle compare
        for (int c = 0; c < 4000; c++) begin
            if (mst == 0) op = pick();
            memready = ($urandom_range(0, 3) != 0);
            if (reset) reset = 1'b0;
            else if ($urandom_range(0, 149) == 0) begin
                #1 reset = 1'b1;
            end
            @(posedge clk); #1;
        end

        @(posedge clk); #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout actual=running required=finished");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

endmodule
